spike_class_decoder: RTL and testbench

- Output-side decoder for the SNN classifier.
- Consumes the <ACC_BITS,6> spike words produced by the NUM_CLASSES output LIF neurons, one word per neuron per timestep.
- Counts spikes per class over NUM_STEPS timesteps, then registers the argmax class with a valid/ready handshake toward the AXI-facing wrapper.
- Sits between the output LIF layer and the result register of the network IP.

---
 rtl/spike_class_decoder.sv | 117 +++++++++++
 tb/tb_spike_class_decoder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/spike_class_decoder.sv
// Output-side decoder for the SNN classifier: counts spikes per output class
// over NUM_STEPS timesteps, then presents the argmax class via valid/ready.

// Per-class spike counter; cleared at inference start, bumped on each spiking beat.
module spike_class_cnt #(
  parameter int CNT_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  output logic [CNT_BITS-1:0] cnt
);
  // clear has priority over increment; both only matter in their own FSM state
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc)   cnt <= cnt + 1'b1;
  end
endmodule

module spike_class_decoder #(
  parameter int ACC_BITS    = 8,
  parameter int NUM_CLASSES = 3,
  parameter int NUM_STEPS   = 25,
  parameter int CNT_BITS    = 5,
  parameter int CLS_BITS    = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            spk_valid,
  input  logic [NUM_CLASSES*ACC_BITS-1:0] spk_in,
  output logic                            busy,
  output logic                            class_valid,
  input  logic                            class_ready,
  output logic [CLS_BITS-1:0]             class_id,
  output logic [CNT_BITS-1:0]             class_count,
  output logic                            tie
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_ARGMAX  = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;
  localparam logic [CNT_BITS-1:0] LAST_STEP = CNT_BITS'(NUM_STEPS - 1);

  logic [1:0]                            state;
  logic [CNT_BITS-1:0]                   step;
  logic [NUM_CLASSES-1:0][CNT_BITS-1:0]  cnt;
  logic [NUM_CLASSES-1:0]                hit;
  logic                                  clr, accept;
  logic [CLS_BITS-1:0]                   best_id;
  logic [CNT_BITS-1:0]                   best_cnt;
  logic                                  best_tie;

  assign clr         = (state == S_IDLE) && start;
  assign accept      = (state == S_COLLECT) && spk_valid;
  assign busy        = (state != S_IDLE);
  assign class_valid = (state == S_DONE);

  // one counter per output neuron; any nonzero spike word counts as a spike
  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_cls
    assign hit[g] = accept && (spk_in[g*ACC_BITS +: ACC_BITS] != '0);
    spike_class_cnt #(.CNT_BITS(CNT_BITS)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (hit[g]),
      .cnt (cnt[g])
    );
  end

  // argmax with strict '>' so the lowest index wins ties; tie flags any other equal class
  always_comb begin
    best_id  = '0;
    best_cnt = cnt[0];
    best_tie = 1'b0;
    for (int i = 1; i < NUM_CLASSES; i++) begin
      if (cnt[i] > best_cnt) begin
        best_id  = CLS_BITS'(i);
        best_cnt = cnt[i];
      end
    end
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if ((cnt[i] == best_cnt) && (CLS_BITS'(i) != best_id)) best_tie = 1'b1;
    end
  end

  // control FSM, step counter and result registers (results persist until next ARGMAX)
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      step        <= '0;
      class_id    <= '0;
      class_count <= '0;
      tie         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          step  <= '0;
          state <= S_COLLECT;
        end
        S_COLLECT: if (spk_valid) begin
          step <= step + 1'b1;
          if (step == LAST_STEP) state <= S_ARGMAX;
        end
        S_ARGMAX: begin
          class_id    <= best_id;
          class_count <= best_cnt;
          tie         <= best_tie;
          state       <= S_DONE;
        end
        S_DONE: if (class_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spike_class_decoder.sv
// Directed bench for spike_class_decoder: reset, clear winner, ties,
// gaps with backpressure, and reset in the middle of an inference.
module tb_spike_class_decoder;
  logic        clk = 1'b0;
  logic        rst, start, spk_valid, class_ready;
  logic [23:0] spk_in;
  logic        busy, class_valid, tie;
  logic [1:0]  class_id;
  logic [4:0]  class_count;
  int          checks = 0;
  int          errors = 0;

  spike_class_decoder dut (
    .clk(clk), .rst(rst), .start(start), .spk_valid(spk_valid), .spk_in(spk_in),
    .busy(busy), .class_valid(class_valid), .class_ready(class_ready),
    .class_id(class_id), .class_count(class_count), .tie(tie)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [1:0] id, input logic [4:0] cnt, input logic t);
    chk({tag, "_valid"}, 32'(class_valid), 32'd1);
    chk({tag, "_id"},    32'(class_id),    32'(id));
    chk({tag, "_count"}, 32'(class_count), 32'(cnt));
    chk({tag, "_tie"},   32'(tie),         32'(t));
  endtask

  task automatic beat(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    spk_valid = 1'b1;
    spk_in    = {c2, c1, c0};
    tick();
    spk_valid = 1'b0;
    spk_in    = '0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // last beat was just sampled: ARGMAX this cycle, DONE next
  task automatic wait_done(input string tag);
    chk({tag, "_argmax_novalid"}, 32'(class_valid), 32'd0);
    chk({tag, "_argmax_busy"},    32'(busy),        32'd1);
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; spk_valid = 1'b0; class_ready = 1'b0; spk_in = '0;
    #1;
    // reset with random inputs
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom); spk_valid = 1'($urandom); class_ready = 1'($urandom);
      spk_in = 24'($urandom);
      tick();
    end
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_valid", 32'(class_valid), 32'd0);
    chk("rst_id",    32'(class_id),    32'd0);
    chk("rst_count", 32'(class_count), 32'd0);
    chk("rst_tie",   32'(tie),         32'd0);
    rst = 1'b0; start = 1'b0; class_ready = 1'b0;

    // beats without start are ignored
    for (int b = 0; b < 25; b++) beat(8'h40, 8'h40, 8'h40);
    chk("nostart_busy",  32'(busy),        32'd0);
    chk("nostart_valid", 32'(class_valid), 32'd0);
    chk("nostart_count", 32'(class_count), 32'd0);

    // clear winner: class1 = 25, class0 = 13, class2 = 0
    do_start();
    chk("cw_busy", 32'(busy), 32'd1);
    for (int b = 0; b < 25; b++) beat((b % 2 == 0) ? 8'h40 : 8'h00, 8'h40, 8'h00);
    wait_done("cw");
    chk_res("cw", 2'd1, 5'd25, 1'b0);
    class_ready = 1'b1;
    tick();
    class_ready = 1'b0;
    chk("cw_ack_busy",  32'(busy),        32'd0);
    chk("cw_ack_valid", 32'(class_valid), 32'd0);
    chk("cw_hold_id",   32'(class_id),    32'd1);

    // tie: class0 = 10, class2 = 10 (arbitrary nonzero words), class1 = 5
    do_start();
    for (int b = 0; b < 25; b++)
      beat((b < 10) ? 8'hC0 : 8'h00, (b < 5) ? 8'h40 : 8'h00,
           (b >= 10 && b < 20) ? 8'h01 : 8'h00);
    wait_done("tie");
    chk_res("tie", 2'd0, 5'd10, 1'b1);
    class_ready = 1'b1; tick(); class_ready = 1'b0;

    // all-zero run
    do_start();
    for (int b = 0; b < 25; b++) beat(8'h00, 8'h00, 8'h00);
    wait_done("zero");
    chk_res("zero", 2'd0, 5'd0, 1'b1);
    class_ready = 1'b1; tick(); class_ready = 1'b0;

    // gaps: class0 = 7, class1 = 5, class2 = 9; gap cycles carry garbage spikes
    do_start();
    for (int b = 0; b < 25; b++) begin
      int ngap = int'($urandom_range(0, 2));
      for (int g = 0; g < ngap; g++) begin
        spk_valid = 1'b0; spk_in = 24'hFFFFFF;
        tick();
      end
      beat((b < 7) ? 8'h40 : 8'h00, (b % 5 == 0) ? 8'h40 : 8'h00,
           (b % 3 == 0) ? 8'h40 : 8'h00);
    end
    spk_valid = 1'b1; spk_in = 24'hFFFFFF;  // ignored in ARGMAX
    wait_done("gap");
    chk_res("gap", 2'd2, 5'd9, 1'b0);
    // backpressure: outputs stable while start/spk_valid toggle
    for (int i = 0; i < 6; i++) begin
      start = i[0]; spk_valid = ~i[0]; spk_in = 24'h404040;
      tick();
      chk_res("hold", 2'd2, 5'd9, 1'b0);
    end
    // handshake with start in the same cycle: start is ignored
    class_ready = 1'b1; start = 1'b1; spk_valid = 1'b0;
    tick();
    class_ready = 1'b0;
    chk("gap_ack_busy",  32'(busy),        32'd0);
    chk("gap_ack_valid", 32'(class_valid), 32'd0);
    start = 1'b0;
    tick();
    chk("gap_start_ignored", 32'(busy), 32'd0);

    // reset mid-run after 12 beats
    do_start();
    for (int b = 0; b < 12; b++) beat(8'h40, 8'h40, 8'h40);
    rst = 1'b1; spk_valid = 1'b1; spk_in = 24'h404040;
    tick();
    rst = 1'b0; spk_valid = 1'b0;
    chk("mid_busy",  32'(busy),        32'd0);
    chk("mid_valid", 32'(class_valid), 32'd0);
    chk("mid_id",    32'(class_id),    32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_novalid", 32'(class_valid), 32'd0);
    end
    do_start();
    for (int b = 0; b < 25; b++) beat(8'h00, 8'h00, 8'h40);
    wait_done("fresh");
    chk_res("fresh", 2'd2, 5'd25, 1'b0);
    class_ready = 1'b1; tick(); class_ready = 1'b0;
    chk("fresh_ack_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
